// File: rtl/mips_chk_pkg.sv
// Shared types for the register-file self-check block.
// State encoding, table entry layout and the PC slot index.
package mips_chk_pkg;

  localparam int CHK_DATA_W = 32;
  localparam int CHK_ADDR_W = 5;
  localparam int CHK_NUM    = 8;
  localparam int PC_IDX     = CHK_NUM;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [CHK_ADDR_W-1:0] addr;
    logic [CHK_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/chk_table.sv
// Expected-value table: one write port, async read by index.
// Reset clears only the valid bits; payload is don't-care when invalid.
module chk_table
  import mips_chk_pkg::*;
#(
  parameter int N  = CHK_NUM,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  entry_t        wentry,
  input  logic [IW-1:0] ridx,
  output entry_t        rentry
);

  entry_t mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (we) begin
      mem[widx] <= wentry;
    end
  end

  assign rentry = mem[ridx];

endmodule

// File: rtl/regfile_checker.sv
// Cycle-triggered register-file checker: freezes the core,
// walks the expected-value table, optionally checks the PC.
module regfile_checker
  import mips_chk_pkg::*;
#(
  parameter int DATA_W     = CHK_DATA_W,
  parameter int ADDR_W     = CHK_ADDR_W,
  parameter int NUM_CHECKS = CHK_NUM,
  parameter int CYC_W      = 32,
  localparam int IW = $clog2(NUM_CHECKS),
  localparam int CW = $clog2(NUM_CHECKS + 2),
  localparam int FW = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  check_cycle,
  input  logic              tbl_we,
  input  logic [IW-1:0]     tbl_idx,
  input  logic              tbl_valid,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              pc_chk_en,
  input  logic [DATA_W-1:0] pc_expected,
  input  logic [DATA_W-1:0] pc_value,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              freeze,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     mismatch_cnt,
  output logic [FW-1:0]     first_fail_idx,
  output logic [DATA_W-1:0] first_fail_act,
  output logic [CYC_W-1:0]  cycle_count
);

  state_t state;

  logic [FW-1:0]     cnt;
  logic [DATA_W-1:0] pc_snap;
  logic              p_valid;
  logic [IW-1:0]     p_idx;
  logic [DATA_W-1:0] p_exp;
  logic [DATA_W-1:0] p_rdata;

  entry_t            rent;
  logic              idle_like;
  logic [CYC_W-1:0]  target;
  logic              last;
  logic              ent_mis;
  logic              pc_mis;
  logic [CW-1:0]     cnt_n;
  logic [FW-1:0]     ff_idx_n;
  logic [DATA_W-1:0] ff_act_n;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign target    = (check_cycle == '0) ? CYC_W'(1) : check_cycle;
  assign last      = (cnt == FW'(NUM_CHECKS));

  chk_table #(
    .N  (NUM_CHECKS),
    .IW (IW)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (tbl_we && idle_like),
    .widx   (tbl_idx),
    .wentry (entry_t'{tbl_valid, tbl_addr, tbl_data}),
    .ridx   (cnt[IW-1:0]),
    .rentry (rent)
  );

  assign rf_raddr = (state == CHECK) ? rent.addr : '0;

  // Stage 2 compares what stage 1 captured on the previous edge.
  always_comb begin
    ent_mis  = (state == CHECK) && (cnt != '0) &&
               p_valid && (p_rdata != p_exp);
    pc_mis   = (state == CHECK) && last && pc_chk_en &&
               (pc_snap != pc_expected);
    cnt_n    = mismatch_cnt + CW'(ent_mis) + CW'(pc_mis);
    ff_idx_n = first_fail_idx;
    ff_act_n = first_fail_act;
    if (mismatch_cnt == '0) begin
      if (ent_mis) begin
        ff_idx_n = FW'(p_idx);
        ff_act_n = p_rdata;
      end else if (pc_mis) begin
        ff_idx_n = FW'(NUM_CHECKS);
        ff_act_n = pc_snap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pc_snap        <= '0;
      p_valid        <= 1'b0;
      p_idx          <= '0;
      p_exp          <= '0;
      p_rdata        <= '0;
      freeze         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_act <= '0;
      cycle_count    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            cycle_count    <= CYC_W'(1);
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_act <= '0;
          end
        end
        RUN: begin
          if (cycle_count == target) begin
            state   <= CHECK;
            pc_snap <= pc_value;
            freeze  <= 1'b1;
            cnt     <= '0;
            p_valid <= 1'b0;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CYC_W'(1);
          end
        end
        CHECK: begin
          mismatch_cnt   <= cnt_n;
          first_fail_idx <= ff_idx_n;
          first_fail_act <= ff_act_n;
          if (!last) begin
            p_valid <= rent.valid;
            p_exp   <= rent.data;
            p_rdata <= rf_rdata;
            p_idx   <= cnt[IW-1:0];
            cnt     <= cnt + FW'(1);
          end else begin
            state  <= DONE;
            freeze <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (cnt_n == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
